// File: rtl/accum_mac_pkg.sv
// Shared types and elaboration helpers for the pipelined multiply/accumulate block.
package accum_mac_pkg;

    typedef enum logic {
        MODE_MULTIPLY = 1'b0,
        MODE_MAC      = 1'b1
    } mac_mode_e;

    localparam int CNT_W = 16;

    // Per-sample controls carried alongside the operands.
    typedef struct packed {
        mac_mode_e  mode;
        logic       subtract;
        logic       unsigned_a;
        logic       unsigned_b;
        logic       load_acc;
        logic [5:0] shift_right;
        logic       round;
        logic       saturate;
    } mac_ctrl_t;

    function automatic int acc_width(input int a_w, input int b_w, input int guard_w);
        return a_w + b_w + guard_w;
    endfunction

    function automatic int pipe_latency(input int input_reg_en, input int output_reg_en);
        return 1 + input_reg_en + output_reg_en;
    endfunction

endpackage

// File: rtl/accum_mac_postproc.sv
// Combinational result conditioning: optional round-half-up, arithmetic right shift,
// then saturate or truncate to OUT_W.
module accum_mac_postproc #(
    parameter int ACC_W = 42,
    parameter int OUT_W = 38
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [5:0]       shift_right,
    input  logic             round,
    input  logic             saturate,
    input  logic             sat_signed,
    output logic [OUT_W-1:0] z,
    output logic             clamp
);

    // One extra bit so the rounding increment cannot wrap the accumulator value.
    localparam int EW = ACC_W + 1;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] sh;
    logic signed [EW-1:0] hi;
    logic signed [EW-1:0] lo;

    always_comb begin
        ext = EW'($signed(acc));
        rnd = ext;
        sh  = ext;
        if (int'(shift_right) >= ACC_W) begin
            // Everything shifted out: rounding always lands on zero, otherwise sign fill.
            sh = round ? '0 : {EW{ext[EW-1]}};
        end else begin
            if (round && (shift_right != 6'd0)) begin
                rnd = ext + (EW'(1) <<< (shift_right - 6'd1));
            end
            sh = rnd >>> shift_right;
        end

        if (sat_signed) begin
            hi = (EW'(1) <<< (OUT_W - 1)) - EW'(1);
            lo = -(EW'(1) <<< (OUT_W - 1));
        end else begin
            hi = (EW'(1) <<< OUT_W) - EW'(1);
            lo = '0;
        end

        clamp = 1'b0;
        z     = sh[OUT_W-1:0];
        if (saturate) begin
            if (sh > hi) begin
                z     = hi[OUT_W-1:0];
                clamp = 1'b1;
            end else if (sh < lo) begin
                z     = lo[OUT_W-1:0];
                clamp = 1'b1;
            end
        end
    end

endmodule

// File: rtl/accum_mac_pipe.sv
// Pipelined signed/unsigned multiplier with burst accumulator and result post-processing.
// Stages: optional input register -> product/accumulate register -> optional output register.
module accum_mac_pipe
    import accum_mac_pkg::*;
#(
    parameter int A_W           = 20,
    parameter int B_W           = 18,
    parameter int GUARD_W       = 4,
    parameter int OUT_W         = 38,
    parameter int BURST_LEN     = 16,
    parameter int INPUT_REG_EN  = 1,
    parameter int OUTPUT_REG_EN = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             mode,
    input  logic             subtract,
    input  logic             unsigned_a,
    input  logic             unsigned_b,
    input  logic             load_acc,
    input  logic [5:0]       shift_right,
    input  logic             round,
    input  logic             saturate,
    output logic [OUT_W-1:0] z,
    output logic             out_valid,
    output logic             burst_done,
    output logic             overflow
);

    localparam int ACC_W = acc_width(A_W, B_W, GUARD_W);
    localparam int PW    = A_W + B_W + 2;

    mac_ctrl_t      in_ctrl;
    mac_ctrl_t      s1_ctrl;
    logic           s1_valid;
    logic [A_W-1:0] s1_a;
    logic [B_W-1:0] s1_b;

    always_comb begin
        in_ctrl.mode        = mac_mode_e'(mode);
        in_ctrl.subtract    = subtract;
        in_ctrl.unsigned_a  = unsigned_a;
        in_ctrl.unsigned_b  = unsigned_b;
        in_ctrl.load_acc    = load_acc;
        in_ctrl.shift_right = shift_right;
        in_ctrl.round       = round;
        in_ctrl.saturate    = saturate;
    end

    if (INPUT_REG_EN != 0) begin : g_in_reg
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1_valid <= 1'b0;
                s1_a     <= '0;
                s1_b     <= '0;
                s1_ctrl  <= '0;
            end else begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a    <= a;
                    s1_b    <= b;
                    s1_ctrl <= in_ctrl;
                end
            end
        end
    end else begin : g_in_comb
        assign s1_valid = in_valid;
        assign s1_a     = a;
        assign s1_b     = b;
        assign s1_ctrl  = in_ctrl;
    end

    logic signed [A_W:0]   a_ext;
    logic signed [B_W:0]   b_ext;
    logic signed [PW-1:0]  prod;
    logic [ACC_W-1:0]      prod_acc;
    logic [ACC_W-1:0]      addend;
    logic [ACC_W-1:0]      acc_d;
    logic [ACC_W-1:0]      acc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  is_mac;
    logic                  fresh;
    logic                  wrap;

    always_comb begin
        a_ext    = {(s1_ctrl.unsigned_a ? 1'b0 : s1_a[A_W-1]), s1_a};
        b_ext    = {(s1_ctrl.unsigned_b ? 1'b0 : s1_b[B_W-1]), s1_b};
        prod     = PW'(a_ext) * PW'(b_ext);
        prod_acc = ACC_W'(prod);
        addend   = s1_ctrl.subtract ? -prod_acc : prod_acc;
        is_mac   = (s1_ctrl.mode == MODE_MAC);
        // MULTIPLY keeps the counter at zero, so a switch into MAC always opens a new burst.
        fresh    = !is_mac || s1_ctrl.load_acc || (cnt_q == '0);
        acc_d    = fresh ? addend : (acc_q + addend);
        cnt_inc  = fresh ? CNT_W'(1) : (cnt_q + CNT_W'(1));
        wrap     = is_mac && (cnt_inc == CNT_W'(BURST_LEN));
    end

    logic       s2_valid;
    logic       s2_bd;
    logic [5:0] s2_shift;
    logic       s2_round;
    logic       s2_sat;
    logic       s2_sat_signed;
    logic       s2_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid      <= 1'b0;
            s2_bd         <= 1'b0;
            acc_q         <= '0;
            cnt_q         <= '0;
            s2_shift      <= '0;
            s2_round      <= 1'b0;
            s2_sat        <= 1'b0;
            s2_sat_signed <= 1'b0;
            s2_load       <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_bd    <= s1_valid && wrap;
            if (s1_valid) begin
                acc_q         <= acc_d;
                cnt_q         <= (!is_mac || wrap) ? '0 : cnt_inc;
                s2_shift      <= s1_ctrl.shift_right;
                s2_round      <= s1_ctrl.round;
                s2_sat        <= s1_ctrl.saturate;
                s2_sat_signed <= !(s1_ctrl.unsigned_a && s1_ctrl.unsigned_b);
                s2_load       <= s1_ctrl.load_acc;
            end
        end
    end

    logic [OUT_W-1:0] pp_z;
    logic             pp_clamp;

    accum_mac_postproc #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_postproc (
        .acc         (acc_q),
        .shift_right (s2_shift),
        .round       (s2_round),
        .saturate    (s2_sat),
        .sat_signed  (s2_sat_signed),
        .z           (pp_z),
        .clamp       (pp_clamp)
    );

    // Sticky history of earlier results; the current result folds in its own clamp.
    logic ov_hist_q;
    logic ov_now;

    assign ov_now = (s2_load ? 1'b0 : ov_hist_q) | pp_clamp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ov_hist_q <= 1'b0;
        end else if (s2_valid) begin
            ov_hist_q <= ov_now;
        end
    end

    if (OUTPUT_REG_EN != 0) begin : g_out_reg
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                z          <= '0;
                out_valid  <= 1'b0;
                burst_done <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                out_valid  <= s2_valid;
                burst_done <= s2_bd;
                if (s2_valid) begin
                    z        <= pp_z;
                    overflow <= ov_now;
                end
            end
        end
    end else begin : g_out_comb
        assign z          = pp_z;
        assign out_valid  = s2_valid;
        assign burst_done = s2_bd;
        assign overflow   = ov_now;
    end

endmodule

// File: tb/tb_accum_mac_pipe.sv
// Directed bench: two instances (38-bit output, latency 2; 16-bit output, latency 3)
// share stimulus; each output is checked against hand-computed values every cycle.
module tb_accum_mac_pipe;
    import accum_mac_pkg::*;

    localparam int LAT0 = pipe_latency(1, 0);
    localparam int LAT1 = pipe_latency(1, 1);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [19:0] a = '0;
    logic [17:0] b = '0;
    logic        mode = 1'b0;
    logic        subtract = 1'b0;
    logic        unsigned_a = 1'b0;
    logic        unsigned_b = 1'b0;
    logic        load_acc = 1'b0;
    logic [5:0]  shift_right = '0;
    logic        round = 1'b0;
    logic        saturate = 1'b0;

    logic [37:0] z0;
    logic        out_valid0, burst_done0, overflow0;
    logic [15:0] z1;
    logic        out_valid1, burst_done1, overflow1;

    always #5 clk = ~clk;

    accum_mac_pipe #(
        .A_W(20), .B_W(18), .GUARD_W(4), .OUT_W(38), .BURST_LEN(4),
        .INPUT_REG_EN(1), .OUTPUT_REG_EN(0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
        .subtract(subtract), .unsigned_a(unsigned_a), .unsigned_b(unsigned_b),
        .load_acc(load_acc), .shift_right(shift_right), .round(round), .saturate(saturate),
        .z(z0), .out_valid(out_valid0), .burst_done(burst_done0), .overflow(overflow0)
    );

    accum_mac_pipe #(
        .A_W(20), .B_W(18), .GUARD_W(4), .OUT_W(16), .BURST_LEN(4),
        .INPUT_REG_EN(1), .OUTPUT_REG_EN(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
        .subtract(subtract), .unsigned_a(unsigned_a), .unsigned_b(unsigned_b),
        .load_acc(load_acc), .shift_right(shift_right), .round(round), .saturate(saturate),
        .z(z1), .out_valid(out_valid1), .burst_done(burst_done1), .overflow(overflow1)
    );

    typedef struct packed {
        logic        v;
        logic        bd;
        logic [37:0] z0;
        logic        ov0;
        logic [15:0] z1;
        logic        ov1;
    } exp_t;

    exp_t  exp_line [0:3];
    exp_t  last;
    int    n_assert = 0;
    int    n_fail = 0;
    string step_name = "init";

    task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s %s: observed %0h expected %0h", step_name, tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        exp_t e0;
        exp_t e1;
        e0 = exp_line[LAT0-1];
        e1 = exp_line[LAT1-1];
        chk("out_valid0",  38'(out_valid0),  38'(e0.v));
        chk("burst_done0", 38'(burst_done0), 38'(e0.bd));
        chk("z0",          z0,               e0.z0);
        chk("overflow0",   38'(overflow0),   38'(e0.ov0));
        chk("out_valid1",  38'(out_valid1),  38'(e1.v));
        chk("burst_done1", 38'(burst_done1), 38'(e1.bd));
        chk("z1",          38'(z1),          38'(e1.z1));
        chk("overflow1",   38'(overflow1),   38'(e1.ov1));
    endtask

    task automatic clear_expect();
        for (int i = 0; i < 4; i++) exp_line[i] = '0;
        last = '0;
    endtask

    task automatic tick(input exp_t e);
        for (int i = 3; i > 0; i--) exp_line[i] = exp_line[i-1];
        exp_line[0] = e;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic sample(input logic [19:0] ta, input logic [17:0] tb, input logic tmode,
                          input logic tsub, input logic tua, input logic tub, input logic tload,
                          input logic [5:0] tsh, input logic trnd, input logic tsat,
                          input logic [37:0] ez0, input logic [15:0] ez1,
                          input logic ebd, input logic eov1);
        exp_t e;
        a = ta; b = tb; mode = tmode; subtract = tsub;
        unsigned_a = tua; unsigned_b = tub; load_acc = tload;
        shift_right = tsh; round = trnd; saturate = tsat;
        in_valid = 1'b1;
        e.v = 1'b1; e.bd = ebd; e.z0 = ez0; e.ov0 = 1'b0; e.z1 = ez1; e.ov1 = eov1;
        last = e;
        tick(e);
    endtask

    task automatic bubble();
        exp_t e;
        in_valid = 1'b0;
        e = last;
        e.v = 1'b0;
        e.bd = 1'b0;
        tick(e);
    endtask

    initial begin
        clear_expect();
        repeat (3) @(negedge clk);
        step_name = "reset";
        check_outputs();
        reset = 1'b1;

        // Unsigned full-scale multiply.
        step_name = "mult_unsigned";
        sample(20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0,
               38'h3F_FFEC_0001, 16'h0001, 1'b0, 1'b0);
        bubble();

        // Signed MAC bursts of 4, with a bubble inside the second burst.
        step_name = "mac_burst";
        sample(20'd3, -18'sd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd6,  -16'sd6,  1'b0, 1'b0);
        sample(20'd3, -18'sd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd12, -16'sd12, 1'b0, 1'b0);
        sample(20'd3, -18'sd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd18, -16'sd18, 1'b0, 1'b0);
        sample(20'd3, -18'sd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd24, -16'sd24, 1'b1, 1'b0);
        sample(20'd3, -18'sd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd6,  -16'sd6,  1'b0, 1'b0);
        bubble();
        sample(20'd3, -18'sd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd12, -16'sd12, 1'b0, 1'b0);
        sample(20'd3, -18'sd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd18, -16'sd18, 1'b0, 1'b0);
        sample(20'd3, -18'sd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd24, -16'sd24, 1'b1, 1'b0);

        // Subtracting MAC with a mid-burst reload; burst_done moves to the 4th sample after it.
        step_name = "mac_sub_reload";
        sample(20'd100, 18'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd100, -16'sd100, 1'b0, 1'b0);
        sample(20'd100, 18'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd200, -16'sd200, 1'b0, 1'b0);
        sample(20'd100, 18'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, -38'sd100, -16'sd100, 1'b0, 1'b0);
        sample(20'd100, 18'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd200, -16'sd200, 1'b0, 1'b0);
        sample(20'd100, 18'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd300, -16'sd300, 1'b0, 1'b0);
        sample(20'd100, 18'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd400, -16'sd400, 1'b1, 1'b0);
        sample(20'd100, 18'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd100, -16'sd100, 1'b0, 1'b0);

        // Saturation on the 16-bit instance, sticky overflow, clear on load.
        step_name = "saturate";
        sample(20'd1000, 18'd1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b1, 38'd1000000, 16'h7FFF, 1'b0, 1'b1);
        sample(20'd1000, 18'd1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 38'd2000000, 16'h7FFF, 1'b0, 1'b1);
        sample(20'd1000, 18'd1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 38'd3000000, 16'hC6C0, 1'b0, 1'b1);
        sample(20'd1000, 18'd1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 38'd1000000, 16'h4240, 1'b0, 1'b0);
        sample(20'd1000, 18'd1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b1, -38'sd1000000, 16'h8000, 1'b0, 1'b1);
        sample(20'd1000, 18'd1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 38'd1000000, 16'hFFFF, 1'b0, 1'b1);
        bubble();

        // Rounding and arithmetic shift, positive and negative products.
        step_name = "round_shift";
        sample(20'd2,    18'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 1'b1, 1'b0, 38'd2,     16'd2,     1'b0, 1'b1);
        sample(20'd2,    18'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 1'b0, 1'b0, 38'd1,     16'd1,     1'b0, 1'b1);
        sample(-20'sd2,  18'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 1'b1, 1'b0, -38'sd1,   -16'sd1,   1'b0, 1'b1);
        sample(-20'sd2,  18'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 1'b0, 1'b0, -38'sd2,   -16'sd2,   1'b0, 1'b1);

        // Reset in the middle of a burst with a sample being presented.
        step_name = "reset_mid_burst";
        sample(20'd3, -18'sd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd6,  -16'sd6,  1'b0, 1'b1);
        sample(20'd3, -18'sd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -38'sd12, -16'sd12, 1'b0, 1'b1);
        in_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        clear_expect();
        check_outputs();
        @(negedge clk);
        reset = 1'b1;

        step_name = "after_reset";
        sample(20'd5, 18'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 38'd35, 16'd35, 1'b0, 1'b0);
        repeat (3) bubble();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_mac_pipe.md
ACCUM_MAC_PIPE -- requirements
Module: accum_mac_pipe

Interface
REQ-001 Parameter A_W, default 20, width of multiplicand a.
REQ-002 Parameter B_W, default 18, width of multiplier b.
REQ-003 Parameter GUARD_W, default 4, accumulator guard bits; ACC_W = A_W+B_W+GUARD_W.
REQ-004 Parameter OUT_W, default 38, output width z; OUT_W <= ACC_W.
REQ-005 Parameter BURST_LEN, default 16, samples per accumulation burst in MAC mode, range 1..65535.
REQ-006 Parameter INPUT_REG_EN, default 1, 1 = input register stage present.
REQ-007 Parameter OUTPUT_REG_EN, default 0, 1 = output register stage present.
REQ-008 clk  input  1  sole clock, rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 in_valid  input  1  a, b and controls are sampled when high.
REQ-011 a  input  A_W  operand A.
REQ-012 b  input  B_W  operand B.
REQ-013 mode  input  1  0 = MULTIPLY (z = a*b), 1 = MAC (accumulate).
REQ-014 subtract  input  1  1 = accumulator minus product.
REQ-015 unsigned_a / unsigned_b  input  1 each  1 = operand unsigned, 0 = two's complement.
REQ-016 load_acc  input  1  1 = sample starts a fresh accumulation (acc = ±product).
REQ-017 shift_right  input  6  arithmetic right shift applied to result.
REQ-018 round  input  1  1 = round-half-up before shift.
REQ-019 saturate  input  1  1 = clamp to OUT_W range instead of truncate.
REQ-020 z  output  OUT_W  result.
REQ-021 out_valid  output  1  z holds a new result this cycle.
REQ-022 burst_done  output  1  one-cycle pulse coincident with out_valid of the last sample of a MAC burst.
REQ-023 overflow  output  1  sticky; set when saturation clamps; cleared by load_acc sample or reset.

Function
REQ-024 Latency from the sampling edge to out_valid SHALL be 1+INPUT_REG_EN+OUTPUT_REG_EN cycles, fixed, fully pipelined (one sample per cycle).
REQ-025 Product SHALL be computed at A_W+B_W+2 bits with per-operand sign extension per unsigned_a/unsigned_b, then extended to ACC_W.
REQ-026 MULTIPLY: acc <= ±product each valid sample; burst counter held at 0; burst_done stays low.
REQ-027 MAC: acc <= ±product when load_acc=1 or burst counter = 0, else acc <= acc ± product.
REQ-028 Burst counter SHALL increment per valid MAC sample and wrap to 0 after BURST_LEN samples; wrap sample raises burst_done.
REQ-029 load_acc=1 mid-burst SHALL restart counter at 1 (that sample counts as first).
REQ-030 Switching mode between samples SHALL reset burst counter to 0 at the switching sample before applying REQ-026/027.
REQ-031 Post-processing order: add 2^(shift_right-1) if round and shift_right>0, arithmetic shift, then saturate or truncate to OUT_W; accumulator itself never saturates (wraps in ACC_W).
REQ-032 Saturation bounds: signed if either operand signed, else unsigned [0, 2^OUT_W-1].
REQ-033 in_valid low SHALL hold acc, counter and z; out_valid low in the corresponding output cycle.

Reset
REQ-034 reset low SHALL immediately clear all pipeline registers, acc, counter; z=0, out_valid=0, burst_done=0, overflow=0.
REQ-035 Samples in flight at reset SHALL be discarded; first sample after release starts a new burst.

Structure
REQ-036 Package accum_mac_pkg SHALL hold mode constants, ACC_W derivation function and latency constant function.
REQ-037 Sub-module accum_mac_postproc SHALL implement round/shift/saturate combinationally.

Verification
REQ-038 MULTIPLY, unsigned, a=20'hFFFFF, b=18'h3FFFF -> z=38'h3F_FFEC_0001 after latency, no overflow.
REQ-039 MAC, BURST_LEN=4, signed, a=3,b=-2 x8 samples -> z=-6,-12,-18,-24,-6..-24; burst_done on samples 4 and 8.
REQ-040 MAC subtract, a=100,b=1, load_acc on sample 3 -> z=-100,-200,-100, counter restart shown by burst_done timing.
REQ-041 OUT_W=16, saturate=1, signed, a=b=1000 accumulated -> z clamps 32767, overflow set; saturate=0 -> truncated value.
REQ-042 shift_right=2, round=1, product 6 -> z=2; round=0 -> z=1.
REQ-043 reset asserted mid-burst with in_valid high -> outputs 0 same cycle; post-release sample z equals its single product.
